prco_regs_arb: RTL and testbench
================================

# prco_regs_arb

Write-back arbiter and hazard scoreboard for the PRCO 8×16-bit register set. Three write-back sources compete for the register set's single write port:

- requester 0: ALU
- requester 1: load/store unit
- requester 2: stack unit (SP/BP updates)

The block grants them round-robin and drives the registered write port (we/seld/datd). A per-register pending scoreboard lets the issue stage detect read-after-write hazards before sampling read ports A/B.

## Interface
Parameters:
- DW, 16, data width of the write-back bus
- AW, 3, register select width (2^AW registers)

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req  in  3  write-back request, one bit per requester
- i_sel0 / i_sel1 / i_sel2  in  AW each  destination register per requester
- i_dat0 / i_dat1 / i_dat2  in  DW each  write data per requester
- q_gnt  out  3  one-hot grant, combinational from i_req and the RR pointer
- q_we  out  1  register-set write enable (registered)
- q_seld  out  AW  register-set write select (registered)
- q_datd  out  DW  register-set write data (registered)
- i_claim  in  1  issue stage marks a destination register as pending
- i_claim_sel  in  AW  register being claimed
- i_rd_en  in  1  issue stage intends to read ports A/B this cycle
- i_rd_sela / i_rd_selb  in  AW  registers to be read
- q_hazard  out  1  i_rd_en && (pending[i_rd_sela] || pending[i_rd_selb]), combinational
- q_pending  out  2^AW  scoreboard bits, registered

## Operation
- **Handshake:**
  - A requester raises i_req[k] with i_selk/i_datk stable and holds all three until q_gnt[k]=1 in a cycle. The transfer completes in that cycle.
  - The requester may drop i_req[k] or present new data in the following cycle.
- **Arbitration:**
  - Round-robin pointer `ptr` (0..2) names the highest-priority requester. Search order is ptr, ptr+1, ptr+2 mod 3.
  - At most one q_gnt bit is set, and only for a requesting source. q_gnt=0 when i_req=0 or while i_reset=1.
  - On a grant to k, ptr <= (k+1) mod 3. With no grant, ptr holds.
- **Write port:**
  - On a grant to k: q_we <= 1, q_seld <= i_selk, q_datd <= i_datk.
  - Otherwise q_we <= 0; q_seld and q_datd hold their previous values.
- **Scoreboard:**
  - pending[i_claim_sel] <= 1 when i_claim=1.
  - pending[q_seld] <= 0 when q_we=1, i.e. the same edge the register set commits the write.
  - Claim and clear of the same register in one cycle: claim wins (bit ends at 1).
  - Claim and clear of different registers both take effect.
  - Claiming an already-pending register is legal; the bit stays at 1. Write-after-write ordering is the issue stage's responsibility.
- No zero register: writes to any of the 8 registers are honoured, including SP and BP.

## Timing
- **Reset values:** q_we=0, q_seld=0, q_datd=0, q_pending=0, ptr=0, q_gnt=0 while i_reset=1.
- Reset asserted mid-transfer discards any pending grant. q_we is 0 in the cycle after the reset edge.
- **Grant-to-write latency:** grant in cycle N; q_we/q_seld/q_datd valid in cycle N+1. The register set writes at the end of N+1.
- **Hazard release:** pending clears at the end of N+1. q_hazard for that register deasserts in N+2, which is the first cycle a read returns the new value.
- **Back-to-back grants:** one per cycle. Three continuous requesters are each served every 3 cycles, with no idle cycle on q_we.
- **Starvation bound:** a held request is granted within 3 cycles.

## Test plan
- **Single write:**
  - Stimulus: reset, then i_req=3'b001, i_sel0=3, i_dat0=16'hBEEF for one cycle.
  - Required: q_gnt=3'b001 in that cycle; next cycle q_we=1, q_seld=3, q_datd=16'hBEEF; the cycle after, q_we=0.
- **Round-robin fairness:**
  - Stimulus: i_req=3'b111 held 6 cycles from reset.
  - Required: grants 0,1,2,0,1,2; q_we=1 continuously from cycle 2 to cycle 7.
- **Hazard lifecycle:**
  - Stimulus: i_claim with sel=5 in cycle 0; i_rd_en with sela=5 every cycle; requester 1 writes reg 5 with grant in cycle 4.
  - Required: q_hazard=1 in cycles 1–5, 0 from cycle 6; q_pending[5] follows the same pattern.
- **Claim/clear collision:**
  - Stimulus: i_claim sel=2 in the same cycle q_we=1 with q_seld=2.
  - Required: q_pending[2]=1 afterwards. Repeating with claim sel=4 instead gives q_pending[2]=0 and q_pending[4]=1.
- **Reset mid-operation:**
  - Stimulus: pending=8'hA5, ptr=2, i_req=3'b111, assert i_reset one cycle.
  - Required: q_gnt=0 during reset; next cycle q_we=0 and q_pending=0; first post-reset grant goes to requester 0.
- **Hold compliance:**
  - Stimulus: requester 2 alone raises i_req while requesters 0 and 1 are active; check i_sel2/i_dat2 unchanged until q_gnt[2].
  - Required: grant to requester 2 within 3 cycles, with q_datd equal to the held i_dat2.

Source files
------------

// File: rtl/prco_regs_arb.sv
`default_nettype none
// ============================================================================
// Module   : prco_regs_arb
// Purpose  : Write-back arbiter and RAW hazard scoreboard for the PRCO
//            8 x 16-bit register set. Three write-back sources (0: ALU,
//            1: load/store unit, 2: stack unit) are granted round-robin onto
//            the single registered write port. A per-register pending bitmap
//            lets the issue stage detect read-after-write hazards.
// Ports    :
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_req[2:0]                  write-back request per source
//   i_sel0..2 / i_dat0..2       destination register / data per source
//   q_gnt[2:0]                  one-hot grant (combinational)
//   q_we / q_seld / q_datd      registered register-set write port
//   i_claim / i_claim_sel       issue stage marks a destination pending
//   i_rd_en / i_rd_sela/selb    issue stage read of ports A/B
//   q_hazard                    combinational RAW hazard flag
//   q_pending[2^AW-1:0]         registered scoreboard bits
// Revision : 1.0 - initial release
// ============================================================================
module prco_regs_arb #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [2:0]          i_req,
    input  logic [AW-1:0]       i_sel0,
    input  logic [AW-1:0]       i_sel1,
    input  logic [AW-1:0]       i_sel2,
    input  logic [DW-1:0]       i_dat0,
    input  logic [DW-1:0]       i_dat1,
    input  logic [DW-1:0]       i_dat2,
    output logic [2:0]          q_gnt,
    output logic                q_we,
    output logic [AW-1:0]       q_seld,
    output logic [DW-1:0]       q_datd,
    input  logic                i_claim,
    input  logic [AW-1:0]       i_claim_sel,
    input  logic                i_rd_en,
    input  logic [AW-1:0]       i_rd_sela,
    input  logic [AW-1:0]       i_rd_selb,
    output logic                q_hazard,
    output logic [(1<<AW)-1:0]  q_pending
);

    localparam int          c_NREG = 1 << AW;
    localparam logic [1:0]  c_PTR0 = 2'd0;
    localparam logic [1:0]  c_PTR1 = 2'd1;
    localparam logic [1:0]  c_PTR2 = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_ptr;       // highest-priority requester (0..2)
    logic               r_we;
    logic [AW-1:0]      r_seld;
    logic [DW-1:0]      r_datd;
    logic [c_NREG-1:0]  r_pending;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic [2:0]         w_gnt;
    logic [1:0]         w_ptr_nxt;
    logic [AW-1:0]      w_wsel;
    logic [DW-1:0]      w_wdat;

    // Search order is ptr, ptr+1, ptr+2 (mod 3). Reset masks every grant
    // so a transfer presented during reset is simply not accepted.
    always_comb begin
        w_gnt = 3'b000;
        if (!i_reset) begin
            case (r_ptr)
                c_PTR1: begin
                    if      (i_req[1]) w_gnt = 3'b010;
                    else if (i_req[2]) w_gnt = 3'b100;
                    else if (i_req[0]) w_gnt = 3'b001;
                end
                c_PTR2: begin
                    if      (i_req[2]) w_gnt = 3'b100;
                    else if (i_req[0]) w_gnt = 3'b001;
                    else if (i_req[1]) w_gnt = 3'b010;
                end
                default: begin
                    if      (i_req[0]) w_gnt = 3'b001;
                    else if (i_req[1]) w_gnt = 3'b010;
                    else if (i_req[2]) w_gnt = 3'b100;
                end
            endcase
        end
    end

    // Pointer moves just past the winner; no grant leaves it in place.
    always_comb begin
        w_ptr_nxt = r_ptr;
        w_wsel    = r_seld;
        w_wdat    = r_datd;
        if (w_gnt[0]) begin
            w_ptr_nxt = c_PTR1;
            w_wsel    = i_sel0;
            w_wdat    = i_dat0;
        end else if (w_gnt[1]) begin
            w_ptr_nxt = c_PTR2;
            w_wsel    = i_sel1;
            w_wdat    = i_dat1;
        end else if (w_gnt[2]) begin
            w_ptr_nxt = c_PTR0;
            w_wsel    = i_sel2;
            w_wdat    = i_dat2;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------
    logic [c_NREG-1:0]  w_clr_mask;
    logic [c_NREG-1:0]  w_set_mask;
    logic [c_NREG-1:0]  w_pending_nxt;

    // The clear is driven by the registered write port, so a bit drops on
    // the same edge the register set commits the data. The set is applied
    // after the clear so a simultaneous claim of the same register wins.
    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (r_we) begin
            w_clr_mask[r_seld] = 1'b1;
        end
        if (i_claim) begin
            w_set_mask[i_claim_sel] = 1'b1;
        end
        w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr     <= c_PTR0;
            r_we      <= 1'b0;
            r_seld    <= '0;
            r_datd    <= '0;
            r_pending <= '0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_we      <= |w_gnt;
            r_seld    <= w_wsel;
            r_datd    <= w_wdat;
            r_pending <= w_pending_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign q_gnt     = w_gnt;
    assign q_we      = r_we;
    assign q_seld    = r_seld;
    assign q_datd    = r_datd;
    assign q_pending = r_pending;
    assign q_hazard  = i_rd_en && (r_pending[i_rd_sela] || r_pending[i_rd_selb]);

endmodule
`default_nettype wire

// File: tb/tb_prco_regs_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_prco_regs_arb
// Purpose  : Self-checking bench for prco_regs_arb. A behavioural model
//            predicts grants, the write port and the pending bitmap; granted
//            writes are queued and popped by a separate write-port monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prco_regs_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  req;
    logic [2:0]  sel [3];
    logic [15:0] dat [3];
    logic        claim;
    logic [2:0]  csel;
    logic        rd_en;
    logic [2:0]  sa, sb;

    logic [2:0]  q_gnt;
    logic        q_we;
    logic [2:0]  q_seld;
    logic [15:0] q_datd;
    logic        q_hazard;
    logic [7:0]  q_pending;

    prco_regs_arb #(.DW(16), .AW(3)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req       (req),
        .i_sel0      (sel[0]),
        .i_sel1      (sel[1]),
        .i_sel2      (sel[2]),
        .i_dat0      (dat[0]),
        .i_dat1      (dat[1]),
        .i_dat2      (dat[2]),
        .q_gnt       (q_gnt),
        .q_we        (q_we),
        .q_seld      (q_seld),
        .q_datd      (q_datd),
        .i_claim     (claim),
        .i_claim_sel (csel),
        .i_rd_en     (rd_en),
        .i_rd_sela   (sa),
        .i_rd_selb   (sb),
        .q_hazard    (q_hazard),
        .q_pending   (q_pending)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (evaluated mid-cycle, after inputs settle)
    // ------------------------------------------------------------------
    typedef struct { logic [2:0] sel; logic [15:0] dat; } wr_t;
    wr_t         exp_q [$];

    int          m_ptr  = 0;
    bit [7:0]    m_pend = '0;
    bit          m_we   = 1'b0;
    bit [2:0]    m_seld = '0;
    bit [15:0]   m_datd = '0;
    bit [2:0]    m_gnt  = '0;
    int          m_wait [3] = '{0, 0, 0};

    always @(negedge clk) begin : model
        bit [2:0] eg;
        bit [7:0] np;
        int       k;
        int       win;
        eg  = '0;
        win = -1;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                k = (m_ptr + i) % 3;
                if (win < 0 && req[k]) win = k;
            end
            if (win >= 0) eg[win] = 1'b1;
        end
        m_gnt = eg;

        chk("gnt",     q_gnt,     eg);
        chk("we",      q_we,      m_we);
        chk("seld",    q_seld,    m_seld);
        chk("datd",    q_datd,    m_datd);
        chk("pending", q_pending, m_pend);
        chk("hazard",  q_hazard,  rd_en && (m_pend[sa] || m_pend[sb]));

        // A held request must be served within 3 cycles.
        for (int j = 0; j < 3; j++) begin
            if (rst) begin
                m_wait[j] = 0;
            end else if (eg[j]) begin
                chk("starve", (m_wait[j] <= 2), 1);
                m_wait[j] = 0;
            end else if (req[j]) begin
                m_wait[j]++;
            end else begin
                m_wait[j] = 0;
            end
        end

        if (rst) begin
            m_ptr  = 0;
            m_pend = '0;
            m_we   = 1'b0;
            m_seld = '0;
            m_datd = '0;
        end else begin
            np = m_pend;
            if (m_we)  np[m_seld] = 1'b0;
            if (claim) np[csel]   = 1'b1;
            m_pend = np;
            if (win >= 0) begin
                exp_q.push_back('{sel: sel[win], dat: dat[win]});
                m_seld = sel[win];
                m_datd = dat[win];
                m_we   = 1'b1;
                m_ptr  = (win + 1) % 3;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-port monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        wr_t e;
        if (q_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got write sel=%0d dat=%0h, expected no write", q_seld, q_datd);
            end else begin
                e = exp_q.pop_front();
                chk("wr_sel", q_seld, e.sel);
                chk("wr_dat", q_datd, e.dat);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req   = 3'b000;
        claim = 1'b0;
        csel  = '0;
        rd_en = 1'b0;
        sa    = '0;
        sb    = '0;
        for (int i = 0; i < 3; i++) begin
            sel[i] = '0;
            dat[i] = '0;
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] held_dat;
        logic        got;
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        // Single write
        do_reset();
        req = 3'b001; sel[0] = 3'd3; dat[0] = 16'hBEEF;
        @(negedge clk); chk("sw_gnt", q_gnt, 3'b001);
        cyc(); idle();
        @(negedge clk); chk("sw_we", q_we, 1); chk("sw_seld", q_seld, 3); chk("sw_datd", q_datd, 16'hBEEF);
        cyc();
        @(negedge clk); chk("sw_we_off", q_we, 0);
        cyc();

        // Round-robin fairness
        do_reset();
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            sel[i] = 3'(i + 1);
            dat[i] = 16'h1000 + 16'(i);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_gnt", q_gnt, 3'b001 << (i % 3));
            if (i > 0) chk("rr_we", q_we, 1);
            cyc();
        end
        idle();
        @(negedge clk); chk("rr_we_last", q_we, 1);
        cyc();
        @(negedge clk); chk("rr_we_off", q_we, 0);
        cyc();

        // Hazard lifecycle
        do_reset();
        for (int c = 0; c < 8; c++) begin
            claim  = (c == 0);
            csel   = 3'd5;
            req    = (c == 4) ? 3'b010 : 3'b000;
            sel[1] = 3'd5;
            dat[1] = 16'h5A5A;
            rd_en  = 1'b1;
            sa     = 3'd5;
            sb     = 3'd0;
            @(negedge clk);
            chk("hz_hazard",  q_hazard,     (c >= 1 && c <= 5));
            chk("hz_pending", q_pending[5], (c >= 1 && c <= 5));
            cyc();
        end
        idle();

        // Claim/clear collision
        do_reset();
        req = 3'b001; sel[0] = 3'd2; dat[0] = 16'h0022; claim = 1'b1; csel = 3'd2;
        cyc();
        req = 3'b000;
        @(negedge clk); chk("cc_we", q_we, 1); chk("cc_seld", q_seld, 2);
        cyc();
        claim = 1'b0;
        @(negedge clk); chk("cc_same", q_pending[2], 1);
        req = 3'b001;
        cyc();
        req = 3'b000; claim = 1'b1; csel = 3'd4;
        @(negedge clk); chk("cc_we2", q_we, 1); chk("cc_seld2", q_seld, 2);
        cyc();
        claim = 1'b0;
        @(negedge clk); chk("cc_clr2", q_pending[2], 0); chk("cc_set4", q_pending[4], 1);
        cyc();

        // Reset mid-operation: pending = A5, ptr = 2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            claim = 1'b1;
            csel  = (i == 0) ? 3'd0 : (i == 1) ? 3'd2 : (i == 2) ? 3'd5 : 3'd7;
            req   = (i == 3) ? 3'b010 : 3'b000;
            sel[1] = 3'd1;
            dat[1] = 16'h1111;
            cyc();
        end
        claim = 1'b0;
        req   = 3'b111;
        rst   = 1'b1;
        @(negedge clk); chk("rm_pend", q_pending, 8'hA5); chk("rm_gnt", q_gnt, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk); chk("rm_we", q_we, 0); chk("rm_pend0", q_pending, 0); chk("rm_first", q_gnt, 3'b001);
        cyc();
        idle();

        // Hold compliance: requester 2 joins active requesters 0 and 1
        do_reset();
        req = 3'b011; sel[0] = 3'd1; dat[0] = 16'hAAAA; sel[1] = 3'd2; dat[1] = 16'hBBBB;
        cyc();
        held_dat = 16'($urandom);
        req[2] = 1'b1; sel[2] = 3'd6; dat[2] = held_dat;
        got = 1'b0;
        for (int i = 0; i < 3 && !got; i++) begin
            @(negedge clk);
            if (q_gnt[2] === 1'b1) got = 1'b1;
            cyc();
        end
        chk("hold_gnt", got, 1);
        req = 3'b000;
        @(negedge clk); chk("hold_datd", q_datd, held_dat); chk("hold_seld", q_seld, 6);
        cyc();
        idle();

        // Randomized traffic obeying the hold-until-granted handshake
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (req[k] && m_gnt[k]) req[k] = 1'b0;
                if (!req[k] && ($urandom % 2 == 0)) begin
                    req[k] = 1'b1;
                    sel[k] = 3'($urandom);
                    dat[k] = 16'($urandom);
                end
            end
            claim = ($urandom % 3 == 0);
            csel  = 3'($urandom);
            rd_en = ($urandom % 2 == 0);
            sa    = 3'($urandom);
            sb    = 3'($urandom);
            rst   = ($urandom % 64 == 0);
            cyc();
        end
        rst = 1'b0;
        idle();
        repeat (3) cyc();
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
